// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   Small lossless FIFO that sits behind the XOR/circular ALU stage. It holds
//   up to DEPTH {result, flags} pairs and presents the oldest one to the
//   consumer. It also tracks two summaries of every accepted result: a sticky
//   OR of the flags, and a saturating run length of consecutive Z=1 results.
//
// Parameters
//   DEPTH        number of buffered entries (power of two, 2..16)
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   in_valid     producer presents a result this cycle
//   in_ready     buffer can accept (not full); depends on registered state only
//   in_y         4-bit result word
//   in_flags     {N,Z,C,V}, N in bit 3
//   out_valid    head entry available (not empty)
//   out_ready    consumer takes the head entry this cycle
//   out_y        head result, 0 when empty
//   out_flags    head flags, 0 when empty
//   count        number of entries currently held
//   sticky_clr   synchronous clear of sticky_flags
//   sticky_flags OR of the flags of all results accepted since the last clear
//   zero_run     consecutive accepted results with Z=1, saturating at 15

module alu_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_y,
  input  logic [3:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_y,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     sticky_clr,
  output logic [3:0]               sticky_flags,
  output logic [3:0]               zero_run
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    sticky_q, sticky_d;
  logic [3:0]    zero_run_q, zero_run_d;

  logic          push;
  logic          pop;
  logic [7:0]    entries [DEPTH];
  logic [7:0]    head;

  // Full/empty come straight from the registered count, so out_ready never
  // reaches in_ready combinationally; a pop on a full buffer does not make
  // room for a push in the same cycle.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Storage: one register per slot, written only when the write pointer
  // selects it. Each slot is reset so nothing undefined can reach the head.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [7:0] entry_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_q <= '0;
        end else if (push && (wr_ptr_q == PW'(gi))) begin
          entry_q <= {in_y, in_flags};
        end
      end

      assign entries[gi] = entry_q;
    end
  endgenerate

  // Head is read combinationally from the registered slots, so an entry
  // written at edge k first shows up after that edge (no bypass from in_*).
  assign head      = entries[rd_ptr_q];
  assign out_y     = out_valid ? head[7:4] : 4'd0;
  assign out_flags = out_valid ? head[3:0] : 4'd0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sticky_d   = sticky_q;
    zero_run_d = zero_run_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A clear together with a push restarts the accumulation from the
    // incoming flags rather than dropping them.
    if (push) begin
      sticky_d = sticky_clr ? in_flags : (sticky_q | in_flags);
    end else if (sticky_clr) begin
      sticky_d = 4'd0;
    end

    if (push) begin
      if (in_flags[2]) begin
        zero_run_d = (zero_run_q == 4'd15) ? 4'd15 : (zero_run_q + 4'd1);
      end else begin
        zero_run_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sticky_q   <= '0;
      zero_run_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      zero_run_q <= zero_run_d;
    end
  end

  assign count        = count_q;
  assign sticky_flags = sticky_q;
  assign zero_run     = zero_run_q;

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of result entries buffered (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  producer presents a result this cycle.
REQ-005 SHALL have port in_ready  output  1  buffer accepts a result this cycle.
REQ-006 SHALL have port in_y  input  4  result word from the XOR/circular ALU stage.
REQ-007 SHALL have port in_flags  input  4  {N,Z,C,V} from the ALU stage, N in bit 3.
REQ-008 SHALL have port out_valid  output  1  head entry available.
REQ-009 SHALL have port out_ready  input  1  consumer takes head entry this cycle.
REQ-010 SHALL have port out_y  output  4  head entry result.
REQ-011 SHALL have port out_flags  output  4  head entry {N,Z,C,V}.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  entries currently held.
REQ-013 SHALL have port sticky_clr  input  1  synchronous clear of sticky_flags.
REQ-014 SHALL have port sticky_flags  output  4  OR of flags of all results accepted since last clear.
REQ-015 SHALL have port zero_run  output  4  consecutive accepted results with Z=1, saturating.

Function
REQ-016 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready, both sampled at the rising clk edge.
REQ-017 SHALL drive in_ready = (count != DEPTH), derived from registered state only; no combinational path from out_ready to in_ready.
REQ-018 SHALL drive out_valid = (count != 0); no bypass: a result pushed at edge k is visible on out_* after edge k, never in the same cycle.
REQ-019 SHALL present the oldest held entry on out_y/out_flags; with count==0, out_y and out_flags SHALL be 0.
REQ-020 SHALL keep out_y/out_flags stable while out_valid=1 and out_ready=0.
REQ-021 SHALL update count by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 SHALL wrap write and read pointers modulo DEPTH; at full with simultaneous pop, in_ready remains 0 that cycle (no push).
REQ-023 SHALL ignore in_y/in_flags when push=0; pushing is lossless, no entry is ever overwritten or dropped.
REQ-024 SHALL set sticky_flags <= sticky_flags | in_flags on push; on sticky_clr without push, sticky_flags <= 0; on sticky_clr with push, sticky_flags <= in_flags.
REQ-025 SHALL update zero_run on push: in_flags[2]=1 -> min(zero_run+1, 15); in_flags[2]=0 -> 0; hold when no push; sticky_clr has no effect on zero_run.
REQ-026 SHALL not alter buffered data or flags; out_flags reproduce in_flags bit-exact.

Reset
REQ-027 SHALL, while rst_n=0, force count=0, pointers=0, out_valid=0, in_ready=1, out_y=0, out_flags=0, sticky_flags=0, zero_run=0, asynchronously without waiting for clk.
REQ-028 SHALL discard all held entries on reset asserted mid-operation; first push after rst_n release behaves as from empty.
REQ-029 SHALL register no push or pop on the edge where rst_n is still 0.

Verification
REQ-030 SHALL cover: push y=0000 flags=0100, then y=1010 flags=1000, out_ready=0 -> count=2, out_y=0000, out_flags=0100, sticky_flags=1100, zero_run=0.
REQ-031 SHALL cover: fill with DEPTH=4 pushes (y=1,2,3,4), in_valid held -> in_ready=0, count=4, fifth value held off; then pop each -> out_y sequence 1,2,3,4, count returns 0, out_y=0.
REQ-032 SHALL cover: count=1 with simultaneous push y=0101 and pop -> count stays 1, next out_y=0101; at count=4 simultaneous in_valid and pop -> only pop occurs, count=3.
REQ-033 SHALL cover: 17 consecutive pushes with flags=0100 -> zero_run saturates at 15; next push flags=0010 -> zero_run=0.
REQ-034 SHALL cover: sticky_flags=1111, sticky_clr with push flags=0001 -> sticky_flags=0001; sticky_clr alone -> 0000.
REQ-035 SHALL cover: count=3, rst_n pulsed low between edges -> outputs reach reset values immediately, count=0, in_ready=1.
